orbit_trail_buffer: RTL and testbench
=====================================

Name: orbit_trail_buffer

Overview:
- Records a decimated history of the three planet positions from the gravity engine.
- Renders that history as small trail dots behind each planet.
- A per-scanline prefetch FSM runs in horizontal blanking and selects the trail points that touch the next line into a few slot registers; active video then hit-tests only those slots.
- Sits between the gravity engine and the pixel renderer; its hit output is merged below the planet colours.

Parameters:
- DEPTH, 8: trail entries per planet. Power of two. 3*DEPTH must be ≤ 150.
- DECIM, 4: frames between successive samples. Must be ≥ 1.
- SLOTS, 4: maximum trail dots displayable on one scanline.
- DOT_HALF, 1: dot half-size. A dot covers |dx| ≤ DOT_HALF and |dy| ≤ DOT_HALF, i.e. a 3x3 square by default.

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- frame_tick  input  1  one-cycle pulse at pix_x==0, pix_y==0
- line_tick  input  1  one-cycle pulse at pix_x==640 (first cycle after active area of each line)
- clear  input  1  synchronous trail erase
- video_active  input  1  high inside the 640x480 area
- pix_x  input  10  current pixel column
- pix_y  input  10  current pixel row
- AX, AY, BX, BY, CX, CY  input  10 each, signed  planet positions from the gravity engine
- trail_hit  output  1  current pixel lies on a trail dot
- trail_id  output  2  planet of the hit dot (0=A, 1=B, 2=C); 0 when no hit
- slot_overflow  output  1  sticky: a line needed more than SLOTS dots
- busy  output  1  high while the line scan FSM is not IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - All entry valid counts, wr_ptr, decimation counter, slots and the FSM are cleared.
  - Outputs: trail_hit=0, trail_id=0, slot_overflow=0, busy=0.
- Sampling:
  - Decimation counter increments on each frame_tick and wraps at DECIM-1.
  - On a frame_tick with counter==DECIM-1, write the positions present on that cycle (pre-update values) into entry wr_ptr: {AX,AY} for plane 0, {BX,BY} for plane 1, {CX,CY} for plane 2.
  - Then wr_ptr increments mod DEPTH, and valid_cnt increments, saturating at DEPTH.
  - Ring wrap: once full, the oldest entry is overwritten.
- Clear:
  - Sets valid_cnt=0, wr_ptr=0 and the decimation counter to 0, and invalidates all slots.
  - If clear coincides with a sample, clear wins and no write occurs.
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE → SCAN on line_tick:
    - Latch target = pix_y + 1, 11-bit, no wrap.
    - Invalidate all slots; set idx=0 and slot_cnt=0.
  - SCAN, one entry per clock, idx = 0 .. 3*DEPTH-1, plane-major:
    - An entry qualifies if it is valid (ring index < valid_cnt) and |entry_y − target| ≤ DOT_HALF, using 11-bit signed arithmetic.
    - If slot_cnt < SLOTS: load slot[slot_cnt] = {entry_x, plane}, mark it valid, increment slot_cnt.
    - Otherwise set slot_overflow=1 and drop the entry.
  - SCAN → DONE after idx = 3*DEPTH-1. DONE → IDLE on the next cycle.
  - Scan length is 3*DEPTH+1 cycles, which must be ≤ 160 (horizontal blanking).
  - line_tick while not IDLE restarts the scan from idx=0 with slots re-invalidated.
  - A sample write during SCAN takes effect immediately; later idx reads see the new data.
  - Lines with target ≥ 480 are scanned normally and are harmless.
  - busy = (state != IDLE).
- Hit test (registered, output aligned to pix_x):
  - Each cycle compare every valid slot against px_next = pix_x + 1, hit if |slot_x − px_next| ≤ DOT_HALF, signed 11-bit.
  - Register the result so that trail_hit reflects the pixel at pix_x on the cycle it is presented.
  - Priority goes to the lowest slot index; trail_id is that slot's plane.
  - Both outputs are forced to 0 when video_active is 0 on the output cycle. A 1-cycle look-ahead on video_active is acceptable provided the output is 0 outside active video.
  - Negative positions never hit.
- slot_overflow is cleared only by reset or clear.

Test Plan:
1. Reset mid-SCAN (assert reset at idx=5) → busy=0, trail_hit=0 immediately; after release no dots appear until DECIM frame_ticks have elapsed.
2. DECIM=4; AX=100, AY=50 held; 4 frame_ticks, then line_tick at pix_y=49 → slot0 = {100, A}. On line 50: trail_hit=1 and trail_id=0 exactly for pix_x = 99..101, 0 elsewhere.
3. Ring wrap: DEPTH=8; issue 9 samples with AY = 10, 20, …, 90 → the entry with y=10 is gone; line_tick targeting row 10 loads 0 slots; targeting row 90 loads 1 slot.
4. Overflow: 5 valid entries with y=200 at x = 10, 30, 50, 70, 90 → slots hold x = 10..70; x=90 never hits; slot_overflow=1 and stays high until clear.
5. clear and sample in the same cycle → no write; a subsequent scan loads 0 slots; slot_overflow=0.
6. Timing: line_tick pulse → busy high for exactly 3*DEPTH+1 = 25 cycles. A second line_tick at cycle 10 → busy extends to 25 cycles after the second pulse.

Source files
------------

// File: rtl/orbit_trail_buffer.sv
// Decimated position history for three planets, rendered as small trail dots.
// A per-line prefetch FSM copies the dots touching the next row into slots.

module orbit_trail_slot_cmp #(
  parameter int DOT_HALF = 1
) (
  input  logic              i_v,
  input  logic signed [9:0] i_sx,
  input  logic [10:0]       i_px,
  output logic              o_hit
);
  localparam logic signed [11:0] DH = 12'(DOT_HALF);

  logic signed [11:0] w_dx;

  assign w_dx  = {{2{i_sx[9]}}, i_sx} - {1'b0, i_px};
  // Negative slot positions are off-screen and must not bleed into column 0.
  assign o_hit = i_v && !i_sx[9] && (w_dx >= -DH) && (w_dx <= DH);
endmodule

module orbit_trail_buffer #(
  parameter int DEPTH    = 8,
  parameter int DECIM    = 4,
  parameter int SLOTS    = 4,
  parameter int DOT_HALF = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              line_tick,
  input  logic              clear,
  input  logic              video_active,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic signed [9:0] AX,
  input  logic signed [9:0] AY,
  input  logic signed [9:0] BX,
  input  logic signed [9:0] BY,
  input  logic signed [9:0] CX,
  input  logic signed [9:0] CY,
  output logic              trail_hit,
  output logic [1:0]        trail_id,
  output logic              slot_overflow,
  output logic              busy
);
  localparam int LD = $clog2(DEPTH);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SW = $clog2(SLOTS + 1);
  localparam int IW = LD + 2;
  localparam logic signed [11:0] DH = 12'(DOT_HALF);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic signed [9:0] r_mx [3][DEPTH];
  logic signed [9:0] r_my [3][DEPTH];
  logic [LD-1:0]     r_wr_ptr;
  logic [LD:0]       r_vcnt;
  logic [DW-1:0]     r_dec;

  logic [IW-1:0]     r_idx;
  logic [10:0]       r_target;
  logic [SW-1:0]     r_slot_cnt;
  logic [SLOTS-1:0]            r_slot_v;
  logic [SLOTS-1:0][9:0]       r_slot_x;
  logic [SLOTS-1:0][1:0]       r_slot_p;
  logic              r_ovf;
  logic              r_hit;
  logic [1:0]        r_id;

  logic              w_dec_last;
  logic              w_sample;
  logic [1:0]        w_plane;
  logic [LD-1:0]     w_e;
  logic signed [9:0] w_ex;
  logic signed [9:0] w_ey;
  logic signed [11:0] w_dy;
  logic              w_qual;
  logic              w_last_idx;
  logic [10:0]       w_px_next;
  logic [SLOTS-1:0]  w_lane_hit;
  logic              w_hit;
  logic [1:0]        w_id;

  // ---------------- sampling ----------------
  assign w_dec_last = (r_dec == DW'(DECIM - 1));
  assign w_sample   = frame_tick && w_dec_last && !clear;

  always_ff @(posedge clk) begin
    if (w_sample) begin
      r_mx[0][r_wr_ptr] <= AX;
      r_my[0][r_wr_ptr] <= AY;
      r_mx[1][r_wr_ptr] <= BX;
      r_my[1][r_wr_ptr] <= BY;
      r_mx[2][r_wr_ptr] <= CX;
      r_my[2][r_wr_ptr] <= CY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec    <= '0;
      r_wr_ptr <= '0;
      r_vcnt   <= '0;
    end else if (clear) begin
      r_dec    <= '0;
      r_wr_ptr <= '0;
      r_vcnt   <= '0;
    end else if (frame_tick) begin
      r_dec <= w_dec_last ? '0 : r_dec + 1'b1;
      if (w_dec_last) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_vcnt != (LD+1)'(DEPTH)) r_vcnt <= r_vcnt + 1'b1;
      end
    end
  end

  // ---------------- scan FSM ----------------
  // idx is plane-major: upper bits select the planet, lower bits the ring entry.
  assign w_plane    = r_idx[IW-1:LD];
  assign w_e        = r_idx[LD-1:0];
  assign w_ex       = r_mx[w_plane][w_e];
  assign w_ey       = r_my[w_plane][w_e];
  assign w_dy       = {{2{w_ey[9]}}, w_ey} - {1'b0, r_target};
  assign w_last_idx = (r_idx == IW'(3 * DEPTH - 1));
  assign w_qual     = (r_state == S_SCAN) && ({1'b0, w_e} < r_vcnt) &&
                      (w_dy >= -DH) && (w_dy <= DH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (line_tick) begin
      w_state_nxt = S_SCAN;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_SCAN:  if (w_last_idx) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_target   <= '0;
      r_slot_cnt <= '0;
      r_slot_v   <= '0;
      r_slot_x   <= '0;
      r_slot_p   <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (line_tick) begin
        r_target   <= {1'b0, pix_y} + 11'd1;
        r_idx      <= '0;
        r_slot_cnt <= '0;
        r_slot_v   <= '0;
      end else begin
        if (r_state == S_SCAN && !w_last_idx) r_idx <= r_idx + 1'b1;
        if (w_qual) begin
          if (r_slot_cnt < SW'(SLOTS)) begin
            for (int s = 0; s < SLOTS; s++) begin
              if (r_slot_cnt == SW'(s)) begin
                r_slot_x[s] <= w_ex;
                r_slot_p[s] <= w_plane;
                r_slot_v[s] <= 1'b1;
              end
            end
            r_slot_cnt <= r_slot_cnt + 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end
      end
      if (clear) begin
        r_slot_v   <= '0;
        r_slot_cnt <= '0;
        r_ovf      <= 1'b0;
      end
    end
  end

  // ---------------- hit test ----------------
  // Evaluate the next pixel so the registered result lines up with pix_x.
  assign w_px_next = {1'b0, pix_x} + 11'd1;

  for (genvar s = 0; s < SLOTS; s++) begin : g_lane
    orbit_trail_slot_cmp #(.DOT_HALF(DOT_HALF)) u_cmp (
      .i_v   (r_slot_v[s]),
      .i_sx  (r_slot_x[s]),
      .i_px  (w_px_next),
      .o_hit (w_lane_hit[s])
    );
  end

  always_comb begin
    w_hit = 1'b0;
    w_id  = 2'd0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (w_lane_hit[s]) begin
        w_hit = 1'b1;
        w_id  = r_slot_p[s];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit <= 1'b0;
      r_id  <= 2'd0;
    end else begin
      r_hit <= w_hit;
      r_id  <= w_id;
    end
  end

  assign trail_hit     = r_hit && video_active;
  assign trail_id      = trail_hit ? r_id : 2'd0;
  assign slot_overflow = r_ovf;
  assign busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_orbit_trail_buffer.sv
// Directed + randomized bench for orbit_trail_buffer against a ring/queue model.
module tb_orbit_trail_buffer;
  localparam int DEPTH = 8, DECIM = 4, SLOTS = 4, DH = 1;

  logic clk = 1'b0;
  logic reset, frame_tick, line_tick, clear, video_active;
  logic [9:0] pix_x, pix_y;
  logic signed [9:0] AX, AY, BX, BY, CX, CY;
  logic trail_hit, slot_overflow, busy;
  logic [1:0] trail_id;

  orbit_trail_buffer #(.DEPTH(DEPTH), .DECIM(DECIM), .SLOTS(SLOTS), .DOT_HALF(DH)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .line_tick(line_tick),
    .clear(clear), .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y),
    .AX(AX), .AY(AY), .BX(BX), .BY(BY), .CX(CX), .CY(CY),
    .trail_hit(trail_hit), .trail_id(trail_id), .slot_overflow(slot_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // reference model
  int mx[3][DEPTH], my[3][DEPTH];
  int m_vcnt, m_wp, m_dec;
  int m_ovf;
  int sl_x[$], sl_p[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic m_reset();
    m_vcnt = 0; m_wp = 0; m_dec = 0; m_ovf = 0;
    sl_x.delete(); sl_p.delete();
  endtask

  task automatic m_clear();
    m_vcnt = 0; m_wp = 0; m_dec = 0; m_ovf = 0;
    sl_x.delete(); sl_p.delete();
  endtask

  function automatic int m_hit(input int x);
    foreach (sl_x[i])
      if (sl_x[i] >= 0 && iabs(x - sl_x[i]) <= DH) return sl_p[i];
    return -1;
  endfunction

  task automatic tick(input int ax, input int ay, input int bx, input int by,
                      input int cx, input int cy, input bit clr);
    @(negedge clk);
    AX = 10'(ax); AY = 10'(ay); BX = 10'(bx); BY = 10'(by); CX = 10'(cx); CY = 10'(cy);
    frame_tick = 1'b1; clear = clr;
    @(negedge clk);
    frame_tick = 1'b0; clear = 1'b0;
    if (clr) m_clear();
    else if (m_dec == DECIM - 1) begin
      mx[0][m_wp] = ax; my[0][m_wp] = ay;
      mx[1][m_wp] = bx; my[1][m_wp] = by;
      mx[2][m_wp] = cx; my[2][m_wp] = cy;
      m_wp = (m_wp + 1) % DEPTH;
      if (m_vcnt < DEPTH) m_vcnt++;
      m_dec = 0;
    end else m_dec++;
  endtask

  // One sample's worth of frame ticks with the positions held.
  task automatic sample(input int ax, input int ay);
    for (int k = 0; k < DECIM; k++) tick(ax, ay, 300, 400, 500, 400, 1'b0);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    m_clear();
  endtask

  task automatic scan(input int row);
    int n, tgt;
    @(negedge clk);
    pix_y = 10'(row); pix_x = 10'd640; video_active = 1'b0; line_tick = 1'b1;
    @(negedge clk);
    line_tick = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("scan_done", 32'(busy), 32'd0);
    sl_x.delete(); sl_p.delete();
    tgt = row + 1;
    for (int p = 0; p < 3; p++)
      for (int e = 0; e < DEPTH; e++)
        if (e < m_vcnt && iabs(my[p][e] - tgt) <= DH) begin
          if (sl_x.size() < SLOTS) begin sl_x.push_back(mx[p][e]); sl_p.push_back(p); end
          else m_ovf = 1;
        end
    chk("overflow", 32'(slot_overflow), 32'(m_ovf));
  endtask

  task automatic line(input int row, input int xlo, input int xhi, output int nhits);
    int e;
    nhits = 0;
    @(negedge clk);
    pix_y = 10'(row); pix_x = 10'(xlo - 1); video_active = 1'b1;
    for (int x = xlo; x <= xhi; x++) begin
      @(negedge clk);
      pix_x = 10'(x);
      #1;
      e = m_hit(x);
      chk($sformatf("hit x=%0d", x), 32'(trail_hit), 32'(e >= 0));
      chk($sformatf("id x=%0d", x), 32'(trail_id), 32'((e >= 0) ? e : 0));
      if (trail_hit === 1'b1) nhits++;
    end
    @(negedge clk);
    video_active = 1'b0;
    #1;
    chk("blank_gate", 32'(trail_hit), 32'd0);
    pix_x = 10'd700;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    reset = 1'b1; frame_tick = 0; line_tick = 0; clear = 0; video_active = 0;
    pix_x = 10'd700; pix_y = 0;
    AX = 0; AY = 0; BX = 0; BY = 0; CX = 0; CY = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_hit", 32'(trail_hit), 0);
    chk("rst_id", 32'(trail_id), 0);
    chk("rst_ovf", 32'(slot_overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // reset in the middle of a scan
    sample(100, 50);
    @(negedge clk); pix_y = 10'd49; line_tick = 1'b1;
    @(negedge clk); line_tick = 1'b0;
    repeat (5) @(posedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    video_active = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_hit", 32'(trail_hit), 0);
    @(negedge clk); reset = 1'b0; video_active = 1'b0;
    m_reset();
    for (int k = 0; k < DECIM - 1; k++) tick(100, 50, 300, 400, 500, 400, 1'b0);
    scan(49);
    line(50, 1, 300, n);
    chk("predecim_nhits", n, 0);

    // single dot
    tick(100, 50, 300, 400, 500, 400, 1'b0);
    scan(49);
    line(50, 1, 300, n);
    chk("dot_nhits", n, 3);

    // ring wrap
    do_clear();
    for (int k = 1; k <= 9; k++) sample(200, 10 * k);
    scan(9);
    line(10, 150, 250, n);
    chk("wrap_gone", n, 0);
    scan(89);
    line(90, 150, 250, n);
    chk("wrap_newest", n, 3);

    // slot overflow
    do_clear();
    for (int k = 0; k < 5; k++) sample(10 + 20 * k, 200);
    scan(199);
    line(200, 1, 120, n);
    chk("ovf_nhits", n, 12);
    chk("ovf_set", 32'(slot_overflow), 1);
    scan(300);
    chk("ovf_sticky", 32'(slot_overflow), 1);
    do_clear();
    chk("ovf_cleared", 32'(slot_overflow), 0);

    // clear coinciding with a sample
    for (int k = 0; k < DECIM - 1; k++) tick(250, 300, 300, 400, 500, 400, 1'b0);
    tick(250, 300, 300, 400, 500, 400, 1'b1);
    scan(299);
    line(300, 200, 300, n);
    chk("clrwin_nhits", n, 0);
    chk("clrwin_ovf", 32'(slot_overflow), 0);

    // busy timing
    @(negedge clk); line_tick = 1'b1;
    @(negedge clk); line_tick = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    chk("busy_len", cnt, 3 * DEPTH + 1);
    @(negedge clk); line_tick = 1'b1;
    @(negedge clk); line_tick = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 10) line_tick = 1'b1;
      @(negedge clk);
      line_tick = 1'b0;
    end
    chk("busy_restart_len", cnt, 10 + 3 * DEPTH + 1);

    // randomized
    for (int r = 0; r < 15; r++) begin
      int nt = $urandom_range(1, 10);
      for (int t = 0; t < nt; t++)
        tick(int'($urandom_range(0, 514)) - 3, $urandom_range(100, 115),
             int'($urandom_range(0, 514)) - 3, $urandom_range(100, 115),
             int'($urandom_range(0, 514)) - 3, $urandom_range(100, 115),
             ($urandom_range(0, 15) == 0));
      begin
        int row = $urandom_range(99, 116);
        scan(row);
        line(row + 1, 1, 520, n);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
